// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Shares one SRAM-like memory port between the instruction
//               cache and the write-back data cache. Exactly one
//               transaction is outstanding at a time. addr_ok/data_ok are
//               routed back to the owning cache only. A sticky err flag is
//               raised when the memory stalls in the data phase.
// Parameters  : TIMEOUT - number of DATA cycles before err is raised
// Macros      : ARB_RR_EN - when defined, a tie is granted to the
//               requester that was not served last (round-robin).
//               Otherwise data wins every tie.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               inst_* / data_*     - cache request ports (req, wr, size,
//                                     addr, wdata in; rdata, addr_ok,
//                                     data_ok out)
//               mem_*               - bridge port (req, wr, size, addr,
//                                     wdata out; rdata, addr_ok, data_ok in)
//               busy, owner, err    - status
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    // instruction cache port
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    // data cache port
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    // memory bridge port
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    // status
    output logic        busy,
    output logic        owner,
    output logic        err
);

    localparam int                  c_TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_TCNT_W-1:0] c_TMAX   = c_TCNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_owner_q, last_owner_d;
    logic                err_q, err_d;
    logic [c_TCNT_W-1:0] tcnt_q, tcnt_d;

    logic w_pick_data;
    logic w_own_req;
    logic w_addr_hs;
    logic w_data_hs;

`ifdef ARB_RR_EN
    // On a tie the requester that was not served last wins.
    assign w_pick_data = (inst_req & data_req) ? ~last_owner_q : data_req;
`else
    // Fixed priority: data wins whenever it requests.
    assign w_pick_data = data_req;
`endif

    assign w_own_req = owner_q ? data_req : inst_req;
    assign w_addr_hs = (state_q == S_ADDR) & w_own_req & mem_addr_ok;
    assign w_data_hs = (state_q == S_DATA) & mem_data_ok;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        tcnt_d       = tcnt_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE: begin
                if (inst_req | data_req) begin
                    owner_d = w_pick_data;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (w_addr_hs) begin
                    state_d = S_DATA;
                    tcnt_d  = '0;
                end else if (!w_own_req) begin
                    // Requester withdrew before the bridge accepted.
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (tcnt_q != c_TMAX) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
                // err rises together with the counter reaching TIMEOUT;
                // the transaction keeps waiting for the bridge.
                if (tcnt_d == c_TMAX) begin
                    err_d = 1'b1;
                end
                if (mem_data_ok) begin
                    last_owner_d = owner_q;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b0;
            tcnt_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            tcnt_q       <= tcnt_d;
            err_q        <= err_d;
        end
    end

    // Owner's fields stay muxed through DATA so the bridge sees stable
    // write data until completion.
    assign mem_req   = (state_q == S_ADDR) & w_own_req;
    assign mem_wr    = owner_q ? data_wr    : inst_wr;
    assign mem_size  = owner_q ? data_size  : inst_size;
    assign mem_addr  = owner_q ? data_addr  : inst_addr;
    assign mem_wdata = owner_q ? data_wdata : inst_wdata;

    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign inst_addr_ok = w_addr_hs & ~owner_q;
    assign data_addr_ok = w_addr_hs &  owner_q;
    assign inst_data_ok = w_data_hs & ~owner_q;
    assign data_data_ok = w_data_hs &  owner_q;

    assign busy  = (state_q != S_IDLE);
    assign owner = owner_q;
    assign err   = err_q;

endmodule
`default_nettype wire
